dmem_sized_wait: RTL and testbench
==================================

// Module: dmem_sized_wait
// PURPOSE
//  Parametrised data memory for the RV32 core. Adds byte/half/word access, sign/zero-extended loads,
//  byte-lane stores and misalignment/range faults. Adds programmable wait states behind a valid/ready
//  request and one-cycle response handshake. Sits between the core's MEM stage and the backing array;
//  the multi-cycle core stalls on req_ready/rsp_valid.
// PARAMETERS
//  DEPTH_WORDS     1024  number of 32-bit words; power of 2, >=4
//  LATENCY         2     wait-state cycles between accept and response, 0..15
//  CLEAR_ON_RESET  1     1: rst_n zeroes every word; 0: contents kept across reset
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   block can accept; high only in IDLE
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend (ignored for word/stores)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   one-cycle response pulse (loads and stores)
//  rsp_rdata     out  32  extended load data; 0 for stores and faults
//  rsp_fault     out  1   misaligned, out-of-range or illegal size
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
//   Array cleared in the same reset when CLEAR_ON_RESET=1.
//  FSM: IDLE -(req_valid)-> WAIT (LATENCY>0) or RESP (LATENCY=0); WAIT counts LATENCY down to 1,
//   then RESP; RESP -> IDLE unconditionally.
//  Accept edge (IDLE & req_valid): fault check; on no fault, store commits with byte strobes and
//   load word is captured together with size/unsigned/addr[1:0]. Rest of request ignored thereafter.
//  Response: request accepted at edge N -> rsp_valid high for exactly cycle N+LATENCY+1.
//   rsp_rdata/rsp_fault valid only while rsp_valid; 0 otherwise.
//  req_ready=0 in WAIT and RESP; req_valid there is ignored, not queued.
//   Throughput: one request per LATENCY+2 cycles.
//  Fault: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
//   A faulting store writes nothing; a faulting load returns 0. The response is still issued
//   with normal latency.
//  Lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0}+1:0; word -> all.
//   Store data is replicated onto the selected lanes; unselected bytes are unchanged.
//  Load extend: byte/half taken from the addressed lane, bit 7/15 replicated unless req_unsigned.
//  Boundaries: highest word (DEPTH_WORDS-1) legal, DEPTH_WORDS*4 faults; addr bits above index
//   range do not alias. Store then load of the same address returns the new data (store committed
//   at accept edge). rst_n low mid-WAIT/RESP drops the in-flight response with no pulse; a store
//   already committed persists only if CLEAR_ON_RESET=0.
// STRUCTURE
//  Package dmem_pkg: size_e {SZ_B,SZ_H,SZ_W,SZ_X}, state_e {IDLE,WAIT,RESP}, LAT_W=4,
//   functions strobe(size,addr_lo) and misaligned(size,addr_lo).
//  Sub-module dmem_lane_align (combinational): store replication + 4-bit strobe, load
//   extract/extend. The top holds the FSM, counter, captured request and array.
// TESTING
//  1 Reset with LATENCY=2: word store 0xDEADBEEF @0x10 at edge N -> rsp_valid only at N+3, fault=0,
//    rdata=0; word load @0x10 -> 0xDEADBEEF.
//  2 Byte store 0x80 @0x21, then loads @0x21: signed byte -> 0xFFFFFF80, unsigned byte -> 0x00000080,
//    word @0x20 -> 0x00008000.
//  3 Half load @0x13 -> fault=1, rdata=0; word store @0x22 -> fault, word @0x20 unchanged;
//    size 11 -> fault.
//  4 DEPTH_WORDS=1024: load @0xFFC legal; store @0x1000 -> fault, word 0 unchanged.
//  5 LATENCY=0: req_valid held high -> accepts every 2nd cycle, rsp_valid the cycle after each
//    accept; req_ready=0 in RESP.
//  6 rst_n low during WAIT after store 0x12345678 @0x40: no rsp_valid; outputs at reset values;
//    load @0x40 -> 0 with CLEAR_ON_RESET=1, 0x12345678 with CLEAR_ON_RESET=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the sized, wait-stated data memory.
package dmem_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic [3:0] strobe(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    strobe = 4'b0001 << addr_lo;
      SZ_H:    strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    strobe = 4'b1111;
      default: strobe = 4'b0000;
    endcase
  endfunction

  // The illegal size is reported here too, so callers need only one fault term.
  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr_lo[0];
      SZ_W:    misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store-data replication and strobes, load extract and extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_strb,
  input  size_e       i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_strb = strobe(i_st_size, i_st_addr_lo);
    case (i_st_size)
      SZ_B:    o_st_data = {4{i_st_data[7:0]}};
      SZ_H:    o_st_data = {2{i_st_data[15:0]}};
      default: o_st_data = i_st_data;
    endcase
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    case (i_ld_size)
      SZ_B:    o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      SZ_W:    o_ld_data = i_ld_word;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_sized_wait.sv
// Data memory with byte/half/word access, fault checks and programmable wait states
// behind a valid/ready request and a one-cycle response pulse.
module dmem_sized_wait
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned LATENCY        = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e           r_state, w_state_nxt;
  logic [LAT_W-1:0] r_cnt, w_cnt_nxt;

  logic        r_fault, r_we, r_unsigned;
  size_e       r_size;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_word;
  logic [31:0] r_mem [DEPTH_WORDS];

  size_e            w_size;
  logic [IDX_W-1:0] w_idx;
  logic             w_oor, w_fault, w_accept;
  logic [31:0]      w_st_data, w_ld_data;
  logic [3:0]       w_st_strb;

  assign w_size   = size_e'(req_size);
  assign w_idx    = req_addr[IDX_W+1:2];
  // Any address bit above the index range faults instead of aliasing.
  assign w_oor    = |req_addr[31:IDX_W+2];
  assign w_fault  = misaligned(w_size, req_addr[1:0]) | w_oor;
  assign w_accept = (r_state == IDLE) & req_valid;

  dmem_lane_align u_align (
    .i_st_size     (w_size),
    .i_st_addr_lo  (req_addr[1:0]),
    .i_st_data     (req_wdata),
    .o_st_data     (w_st_data),
    .o_st_strb     (w_st_strb),
    .i_ld_size     (r_size),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_unsigned (r_unsigned),
    .i_ld_word     (r_word),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = LAT_W'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (r_cnt <= 1) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault    <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_B;
      r_addr_lo  <= '0;
      r_word     <= '0;
    end else if (w_accept) begin
      r_fault    <= w_fault;
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_size     <= w_size;
      r_addr_lo  <= req_addr[1:0];
      r_word     <= r_mem[w_idx];
    end
  end

  generate
    if (CLEAR_ON_RESET) begin : g_mem_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
        end else if (w_accept & req_we & ~w_fault) begin
          for (int unsigned b = 0; b < 4; b++)
            if (w_st_strb[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (w_accept & req_we & ~w_fault) begin
          for (int unsigned b = 0; b < 4; b++)
            if (w_st_strb[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
        end
      end
    end
  endgenerate

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_fault = rsp_valid & r_fault;
  assign rsp_rdata = (rsp_valid & ~r_fault & ~r_we) ? w_ld_data : '0;

endmodule

// File: tb/tb_dmem_sized_wait.sv
// Bench for dmem_sized_wait: three instances (LAT2/clear, LAT2/keep, LAT0/clear).
module tb_dmem_sized_wait;
  import dmem_pkg::*;

  localparam int unsigned LAT_AB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  int unsigned mon;

  logic        ab_valid, c_valid;
  logic        a_ready, a_rv, a_f, b_ready, b_rv, b_f, c_ready, c_rv, c_f;
  logic [31:0] a_rd, b_rd, c_rd;
  logic        m_ready, m_rv, m_f;
  logic [31:0] m_rd;

  assign ab_valid = req_valid & (mon != 2);
  assign c_valid  = req_valid & (mon == 2);

  dmem_sized_wait #(.DEPTH_WORDS(1024), .LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(ab_valid), .req_ready(a_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_fault(a_f));

  dmem_sized_wait #(.DEPTH_WORDS(1024), .LATENCY(2), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(ab_valid), .req_ready(b_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_fault(b_f));

  dmem_sized_wait #(.DEPTH_WORDS(1024), .LATENCY(0), .CLEAR_ON_RESET(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(c_valid), .req_ready(c_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(c_rv), .rsp_rdata(c_rd), .rsp_fault(c_f));

  always_comb begin
    m_ready = a_ready; m_rv = a_rv; m_rd = a_rd; m_f = a_f;
    if (mon == 1) begin
      m_ready = b_ready; m_rv = b_rv; m_rd = b_rd; m_f = b_f;
    end else if (mon == 2) begin
      m_ready = c_ready; m_rv = c_rv; m_rd = c_rd; m_f = c_f;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic fault);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.fault = fault;
    return v;
  endfunction

  function automatic int unsigned lat();
    return (mon == 2) ? 0 : LAT_AB;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    if (m_rv) begin
      if (sb.size() == 0) begin
        chk("spurious rsp_valid", 32'(m_rv), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp cycle", cyc, e.cyc);
        chk("rsp_rdata", m_rd, e.rdata);
        chk("rsp_fault", 32'(m_f), 32'(e.fault));
      end
    end else begin
      if (sb.size() != 0 && cyc >= sb[0].cyc) begin
        chk("rsp_valid missing", 32'(m_rv), 32'd1);
        void'(sb.pop_front());
      end
      chk("rdata outside pulse", m_rd, 32'd0);
      chk("fault outside pulse", 32'(m_f), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_rsp();
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    chk("req_ready before accept", 32'(m_ready), 32'd1);
    e.cyc = cyc + 1 + lat(); e.rdata = v.rdata; e.fault = v.fault;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("response timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    tv.push_back(mk(1, SZ_W, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0));
    tv.push_back(mk(0, SZ_W, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0));
    tv.push_back(mk(0, SZ_W, 1, 32'h10,       32'h0,        32'hDEADBEEF, 0));
    tv.push_back(mk(1, SZ_B, 0, 32'h21,       32'hAAAAAA80, 32'h0,        0));
    tv.push_back(mk(0, SZ_B, 0, 32'h21,       32'h0,        32'hFFFFFF80, 0));
    tv.push_back(mk(0, SZ_B, 1, 32'h21,       32'h0,        32'h00000080, 0));
    tv.push_back(mk(0, SZ_W, 0, 32'h20,       32'h0,        32'h00008000, 0));
    tv.push_back(mk(0, SZ_H, 0, 32'h13,       32'h0,        32'h0,        1));
    tv.push_back(mk(1, SZ_W, 0, 32'h22,       32'h11111111, 32'h0,        1));
    tv.push_back(mk(0, SZ_W, 0, 32'h20,       32'h0,        32'h00008000, 0));
    tv.push_back(mk(0, SZ_X, 0, 32'h20,       32'h0,        32'h0,        1));
    tv.push_back(mk(1, SZ_X, 0, 32'h20,       32'hFFFFFFFF, 32'h0,        1));
    tv.push_back(mk(0, SZ_W, 0, 32'h20,       32'h0,        32'h00008000, 0));
    tv.push_back(mk(1, SZ_W, 0, 32'hFFC,      32'hCAFEF00D, 32'h0,        0));
    tv.push_back(mk(0, SZ_W, 0, 32'hFFC,      32'h0,        32'hCAFEF00D, 0));
    tv.push_back(mk(1, SZ_W, 0, 32'h1000,     32'h55555555, 32'h0,        1));
    tv.push_back(mk(0, SZ_W, 0, 32'h0,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, SZ_W, 0, 32'h1000,     32'h0,        32'h0,        1));
    tv.push_back(mk(1, SZ_W, 0, 32'h80000010, 32'h55555555, 32'h0,        1));
    tv.push_back(mk(0, SZ_W, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0));
    tv.push_back(mk(1, SZ_H, 0, 32'h32,       32'h1234ABCD, 32'h0,        0));
    tv.push_back(mk(0, SZ_H, 0, 32'h32,       32'h0,        32'hFFFFABCD, 0));
    tv.push_back(mk(0, SZ_H, 1, 32'h32,       32'h0,        32'h0000ABCD, 0));
    tv.push_back(mk(0, SZ_W, 0, 32'h30,       32'h0,        32'hABCD0000, 0));
    tv.push_back(mk(0, SZ_B, 0, 32'h33,       32'h0,        32'hFFFFFFAB, 0));
    tv.push_back(mk(0, SZ_B, 1, 32'h30,       32'h0,        32'h0,        0));
    tv.push_back(mk(1, SZ_W, 0, 32'h40,       32'h11223344, 32'h0,        0));
    tv.push_back(mk(1, SZ_B, 0, 32'h42,       32'h00000099, 32'h0,        0));
    tv.push_back(mk(1, SZ_H, 0, 32'h41,       32'h0000FFFF, 32'h0,        1));
    tv.push_back(mk(0, SZ_W, 0, 32'h40,       32'h0,        32'h11993344, 0));
    tv.push_back(mk(0, SZ_H, 0, 32'h40,       32'h0,        32'h00003344, 0));
    tv.push_back(mk(0, SZ_B, 0, 32'h41,       32'h0,        32'h00000033, 0));

    mon = 0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(a_ready), 32'd1);
    chk("reset rsp_valid", 32'(a_rv), 32'd0);
    chk("reset rsp_rdata", a_rd, 32'd0);
    chk("reset rsp_fault", 32'(a_f), 32'd0);
    chk("reset req_ready lat0", 32'(c_ready), 32'd1);
    rst_n = 1'b1;
    step();

    foreach (tv[i]) begin
      issue(tv[i]);
      wait_idle();
    end

    // Request presented during WAIT/RESP must be ignored, not queued.
    issue(mk(0, SZ_W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h10; req_wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      chk("req_ready in WAIT", 32'(m_ready), 32'd0);
      step();
    end
    chk("req_ready in RESP", 32'(m_ready), 32'd0);
    req_valid = 1'b0;
    wait_idle();
    issue(mk(0, SZ_W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    wait_idle();

    // Zero-latency instance with req_valid held high.
    mon = 2;
    issue(mk(1, SZ_W, 0, 32'h10, 32'h0BADF00D, 32'h0, 0));
    wait_idle();
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0; req_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      chk("lat0 req_ready pattern", 32'(m_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) begin
        e.cyc = cyc + 1; e.rdata = 32'h0BADF00D; e.fault = 1'b0;
        sb.push_back(e);
      end
      step();
    end
    req_valid = 1'b0;
    wait_idle();

    // Reset in the middle of WAIT drops the response.
    mon = 0;
    issue(mk(1, SZ_W, 0, 32'h40, 32'h12345678, 32'h0, 0));
    step();
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("mid-wait reset req_ready", 32'(a_ready), 32'd1);
    chk("mid-wait reset rsp_valid", 32'(a_rv), 32'd0);
    chk("mid-wait reset rsp_rdata", a_rd, 32'd0);
    chk("mid-wait reset rsp_fault", 32'(a_f), 32'd0);
    chk("mid-wait reset keep req_ready", 32'(b_ready), 32'd1);
    chk("mid-wait reset keep rsp_valid", 32'(b_rv), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    issue(mk(0, SZ_W, 0, 32'h40, 32'h0, 32'h0, 0));
    wait_idle();
    issue(mk(0, SZ_W, 0, 32'h10, 32'h0, 32'h0, 0));
    wait_idle();
    mon = 1;
    issue(mk(0, SZ_W, 0, 32'h40, 32'h0, 32'h12345678, 0));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
